// File: rtl/fft_input_reorder.sv
// Ping-pong reorder buffer ahead of the 32-point FFT: natural-order writes into one bank
// while the other bank streams out in bit-reversed order.
module fft_input_reorder #(
  parameter int DW    = 17,
  parameter int N     = 32,
  parameter int LOG2N = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_r,
  input  logic [DW-1:0]    in_i,
  output logic             out_valid,
  output logic             out_start,
  output logic [DW-1:0]    out_r,
  output logic [DW-1:0]    out_i,
  output logic [LOG2N-1:0] out_idx
);

  localparam logic [LOG2N-1:0] LAST = {LOG2N{1'b1}};

  logic [2*DW-1:0]  mem [0:1][0:N-1];
  logic [1:0]       full;
  logic             wr_bank;
  logic [LOG2N-1:0] wr_cnt;
  logic             rd_bank;
  logic [LOG2N-1:0] rd_cnt;
  logic             wr_en;
  logic             rd_en;
  logic [LOG2N-1:0] rd_addr;
  logic [2*DW-1:0]  rd_word;
  logic [1:0]       full_nxt;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
    logic [LOG2N-1:0] r;
    for (int b = 0; b < LOG2N; b++) r[b] = v[LOG2N-1-b];
    return r;
  endfunction

  assign in_ready = !full[wr_bank];
  assign wr_en    = in_valid && in_ready;
  assign rd_en    = full[rd_bank];
  assign rd_addr  = bitrev(rd_cnt);
  assign rd_word  = mem[rd_bank][rd_addr];

  // A bank being read is full and a bank being written is not, so the two updates never collide.
  always_comb begin
    full_nxt = full;
    if (rd_en && rd_cnt == LAST) full_nxt[rd_bank] = 1'b0;
    if (wr_en && wr_cnt == LAST) full_nxt[wr_bank] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_bank][wr_cnt] <= {in_r, in_i};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full    <= '0;
      wr_bank <= 1'b0;
      wr_cnt  <= '0;
      rd_bank <= 1'b0;
      rd_cnt  <= '0;
    end else begin
      full <= full_nxt;
      if (wr_en) begin
        wr_cnt <= wr_cnt + 1'b1;
        if (wr_cnt == LAST) wr_bank <= ~wr_bank;
      end
      if (rd_en) begin
        rd_cnt <= rd_cnt + 1'b1;
        if (rd_cnt == LAST) rd_bank <= ~rd_bank;
      end
    end
  end

  // Data and index hold their last values on idle cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_start <= 1'b0;
      out_r     <= '0;
      out_i     <= '0;
      out_idx   <= '0;
    end else if (rd_en) begin
      out_valid <= 1'b1;
      out_start <= (rd_cnt == '0);
      out_r     <= rd_word[2*DW-1:DW];
      out_i     <= rd_word[DW-1:0];
      out_idx   <= rd_cnt;
    end else begin
      out_valid <= 1'b0;
      out_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fft_input_reorder.sv
// Randomized bench for fft_input_reorder against a sample-queue reference model.
module tb_fft_input_reorder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [16:0] in_r = '0;
  logic [16:0] in_i = '0;
  logic        out_valid;
  logic        out_start;
  logic [16:0] out_r;
  logic [16:0] out_i;
  logic [4:0]  out_idx;

  fft_input_reorder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_r(in_r), .in_i(in_i), .out_valid(out_valid), .out_start(out_start),
    .out_r(out_r), .out_i(out_i), .out_idx(out_idx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: completed frames wait in done_q (32 samples each, head frame drains first).
  logic [33:0] done_q[$];
  logic [33:0] part_q[$];
  int          pos = 0;
  int          n_acc = 0;
  logic        exp_valid = 0, exp_start = 0;
  logic [16:0] exp_r = '0, exp_i = '0;
  int          exp_idx = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int rev5(input int k);
    int r = 0;
    for (int b = 0; b < 5; b++) if (((k >> b) & 1) == 1) r += (1 << (4 - b));
    return r;
  endfunction

  function automatic logic model_ready();
    return done_q.size() < 64;
  endfunction

  task automatic model_step();
    logic acc;
    logic [33:0] s;
    acc = in_valid && model_ready();
    if (done_q.size() >= 32) begin
      s = done_q[rev5(pos)];
      exp_r = s[33:17];
      exp_i = s[16:0];
      exp_idx = pos;
      exp_start = (pos == 0);
      exp_valid = 1'b1;
      pos++;
      if (pos == 32) begin
        pos = 0;
        repeat (32) void'(done_q.pop_front());
      end
    end else begin
      exp_valid = 1'b0;
      exp_start = 1'b0;
    end
    if (acc) begin
      part_q.push_back({in_r, in_i});
      n_acc++;
      if (part_q.size() == 32) begin
        foreach (part_q[j]) done_q.push_back(part_q[j]);
        part_q.delete();
      end
    end
  endtask

  task automatic model_reset();
    done_q.delete();
    part_q.delete();
    pos = 0;
    exp_valid = 0; exp_start = 0; exp_r = '0; exp_i = '0; exp_idx = 0;
  endtask

  task automatic check_outputs();
    check("in_ready", 64'(in_ready), 64'(model_ready()));
    check("out_valid", 64'(out_valid), 64'(exp_valid));
    check("out_start", 64'(out_start), 64'(exp_start));
    check("out_r", 64'(out_r), 64'(exp_r));
    check("out_i", 64'(out_i), 64'(exp_i));
    check("out_idx", 64'(out_idx), 64'(exp_idx));
  endtask

  // Drive at negedge, model at posedge, check at next negedge.
  task automatic cycle(input logic v, input logic [16:0] r, input logic [16:0] i);
    in_valid = v; in_r = r; in_i = i;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 17'($urandom), 17'($urandom));
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_r", 64'(out_r), 64'd0);
    check("rst_out_idx", 64'(out_idx), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    #1 rst = 1'b0;
  endtask

  task automatic ramp_frame(input int base);
    for (int n = 0; n < 32; n++) cycle(1'b1, 17'(base + n), 17'(-(base + n)));
  endtask

  initial begin
    int start;
    int bound;
    int first_r [32];
    int seen;
    repeat (2) @(negedge clk);
    check_outputs();
    rst = 1'b0;

    // Ramp frame, also pinned against the literal bit-reversed order.
    seen = 0;
    ramp_frame(0);
    for (int k = 0; k < 40; k++) begin
      cycle(1'b0, '0, '0);
      if (out_valid && seen < 32) begin first_r[seen] = int'(out_r); seen++; end
    end
    check("ramp_count", 64'(seen), 64'd32);
    begin
      int tbl [32] = '{0,16,8,24,4,20,12,28,2,18,10,26,6,22,14,30,
                       1,17,9,25,5,21,13,29,3,19,11,27,7,23,15,31};
      for (int k = 0; k < 32; k++)
        if (k < seen) check("ramp_order", 64'(first_r[k]), 64'(tbl[k]));
    end

    // 96 samples back-to-back: three contiguous frames.
    for (int f = 0; f < 3; f++) ramp_frame(32 * f);
    idle(40);

    // 64 back-to-back random samples, then valid held with random data.
    for (int k = 0; k < 104; k++) cycle(1'b1, 17'($urandom), 17'($urandom));
    idle(70);

    // Random ~50% valid gaps until two frames are accepted.
    start = n_acc;
    bound = 0;
    while (n_acc - start < 64 && bound < 1000) begin
      cycle(1'($urandom_range(0, 1)), 17'($urandom), 17'($urandom));
      bound++;
    end
    check("gap_accept_bound", 64'(n_acc - start >= 64), 64'd1);
    idle(70);

    // Partial frame is held silently, then discarded by reset.
    for (int n = 0; n < 20; n++) cycle(1'b1, 17'($urandom), 17'($urandom));
    idle(50);
    async_reset();
    ramp_frame(100);
    bound = 0;
    while (!(exp_valid && exp_idx == 10) && bound < 60) begin
      cycle(1'b0, '0, '0);
      bound++;
    end
    check("reach_idx10", 64'(exp_valid && exp_idx == 10), 64'd1);
    async_reset();
    ramp_frame(200);
    idle(40);

    // Extreme values, alternating.
    for (int n = 0; n < 32; n++)
      if (n % 2 == 0) cycle(1'b1, 17'h10000, 17'h0FFFF);
      else            cycle(1'b1, 17'h0FFFF, 17'h10000);
    idle(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fft_input_reorder.md
Name: fft_input_reorder

Overview:
- Ping-pong reorder buffer on the input side of the 32-point FFT pipeline.
- Accepts complex samples in natural order through a valid/ready handshake.
- Stores each 32-sample frame in one of two banks, then streams the frame out in 5-bit bit-reversed order, one sample per cycle, with a frame-start marker.
- Streaming fills one bank while the other drains, so sustained throughput is one sample per cycle.

Parameters:
- DW, 17, real/imag sample width (signed two's complement).
- N, 32, frame length; fixed at 32, not generalised.
- LOG2N, 5, index width.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  input sample present
- in_ready  output  1  block can accept a sample this cycle
- in_r  input  DW  input real part, natural order
- in_i  input  DW  input imaginary part, natural order
- out_valid  output  1  out_r/out_i/out_idx valid this cycle
- out_start  output  1  first sample of an output frame
- out_r  output  DW  output real part, bit-reversed order
- out_i  output  DW  output imaginary part, bit-reversed order
- out_idx  output  LOG2N  output position k (0..31) within the frame

Behaviour:
- Interface: one clock; rst asynchronous active-high; no backpressure on the output side.
- Storage: two banks of 32 entries, each entry {re, im}. Per-bank flag full[b].
- Write pointers: wr_bank (1 bit), wr_cnt (5 bits).
- Read pointers: rd_bank (1 bit), rd_cnt (5 bits).
- in_ready is combinational: in_ready = !full[wr_bank].
- Write, on each edge with in_valid && in_ready:
  - mem[wr_bank][wr_cnt] <= {in_r, in_i}; wr_cnt++.
  - When wr_cnt == 31: full[wr_bank] <= 1, wr_bank toggles, wr_cnt wraps to 0.
- Read, on each edge with full[rd_bank] == 1:
  - out_r/out_i <= mem[rd_bank][bitrev5(rd_cnt)].
  - out_idx <= rd_cnt; out_valid <= 1; out_start <= (rd_cnt == 0); rd_cnt++.
  - When rd_cnt == 31: full[rd_bank] <= 0, rd_bank toggles, rd_cnt wraps to 0.
- Idle read edge (full[rd_bank] == 0): out_valid <= 0, out_start <= 0. Data and out_idx hold their last values.
- Output order within a frame: stored sample 0,16,8,24,4,20,12,28,2,18,10,26,6,22,14,30,1,17,9,25,5,21,13,29,3,19,11,27,7,23,15,31.
- Latency: the last (32nd) write accepted at edge k sets full; the first output (stored sample 0) is registered at edge k+1. A frame occupies 32 consecutive out_valid cycles with no gaps.
- Back-to-back frames: if the other bank is full when index 31 is emitted, its index 0 follows on the next edge with out_start = 1, with no bubble.
- Simultaneous events:
  - Clearing full[rd_bank] and setting full[wr_bank] on the same edge is legal. The banks always differ in that case, because a full bank cannot be written.
  - in_ready recomputes from the updated flags in the following cycle.
- Continuous input: in_ready stays 1 indefinitely when in_valid is held high. The drain of bank A completes on the same edge bank B fills.
- Input stall: in_valid low simply pauses wr_cnt. Partial frames are held indefinitely and are never emitted until complete.
- Reset (including mid-frame):
  - Clears full[0..1], wr_bank, wr_cnt, rd_bank and rd_cnt.
  - Outputs: out_valid = 0, out_start = 0, out_r = 0, out_i = 0, out_idx = 0; in_ready = 1 after reset.
  - Memory contents are not reset and are irrelevant.
  - Partially written or partially streamed frames are discarded.
- Arithmetic: no computation on the data; values pass bit-exact. bitrev5 maps b4b3b2b1b0 to b0b1b2b3b4.

Test Plan:
1. Reset, then 32 samples with in_r = n, in_i = -n (n = 0..31) on consecutive cycles → one cycle after the last write, 32 consecutive out_valid cycles:
   - out_r = 0,16,8,24,...,15,31 and out_i the negation.
   - out_idx = 0..31; out_start only on the first of them.
2. in_valid held high for 96 samples → in_ready never drops; three frames emitted contiguously; out_start at frame indices 0, 32 and 64 of the output stream; data per frame matches scenario 1, offset by 32·f.
3. Fill both banks with no read drain possible (write 64 samples back-to-back):
   - in_ready goes low after the 64th acceptance only if bank A has not yet drained; check that in_ready = !full[wr_bank] every cycle.
   - Hold in_valid high with ready low → no sample lost or duplicated.
4. Random in_valid gaps (about 50% duty) over 2 frames → output frames still contiguous 32-cycle bursts; values bit-exact; out_valid low between frames.
5. Assert rst after 20 writes and again mid-stream at out_idx = 10 → out_valid = 0 immediately (async). A fresh 32-sample frame afterwards emits correctly, starting at stored sample 0.
6. Extreme values (in_r = 17'h10000, in_i = 17'h0FFFF alternating) → passed through bit-exact, sign preserved.
